// File: rtl/br_resolve.sv
// br_resolve: compares up to two resolved branches per cycle against their
// fetch-time predictions, redirects fetch on a mispredict and streams
// predictor training updates out of a small FIFO, one entry per cycle.
module br_resolve #(
  parameter int DEPTH         = 4,
  parameter int SQUASH_CYCLES = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex0_valid,
  input  logic [63:0] ex0_pc,
  input  logic        ex0_uncond,
  input  logic        ex0_pred_taken,
  input  logic [63:0] ex0_pred_target,
  input  logic        ex0_taken,
  input  logic [63:0] ex0_target,
  input  logic        ex1_valid,
  input  logic [63:0] ex1_pc,
  input  logic        ex1_uncond,
  input  logic        ex1_pred_taken,
  input  logic [63:0] ex1_pred_target,
  input  logic        ex1_taken,
  input  logic [63:0] ex1_target,
  output logic        ex_ready,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic        ex_br_valid,
  output logic        ex_br,
  output logic        wr_btb_en,
  output logic [63:0] ex_pc_idx,
  output logic [63:0] target_pc,
  output logic [31:0] mispred_cnt,
  output logic        dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = (SQUASH_CYCLES > 1) ? $clog2(SQUASH_CYCLES) : 1;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } state_e;

  typedef struct packed {
    logic        uncond;
    logic        taken;
    logic [63:0] pc;
    logic [63:0] target;
  } entry_t;

  // Handshake: a port transfers in a cycle where exN_valid=1 and the registered
  // ex_ready=1 (which implies RUN). ex_ready promises room for two entries
  // after this cycle's pop; valid asserted while ex_ready=0 is ignored.

  state_e          state_q, state_d;
  logic [SW-1:0]   sq_cnt_q, sq_cnt_d;
  logic            ready_q, ready_d;
  logic            redir_v_q, redir_v_d;
  logic [63:0]     redir_pc_q, redir_pc_d;
  logic [31:0]     mcnt_q, mcnt_d;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cnt_left;

  logic            upd_brv_q, upd_brv_d;
  logic            upd_br_q, upd_br_d;
  logic            upd_btb_q, upd_btb_d;
  logic [63:0]     upd_pc_q, upd_pc_d;
  logic [63:0]     upd_tgt_q, upd_tgt_d;
  entry_t          head_d;

  logic            mis0, mis1;
  logic [63:0]     fix0, fix1;
  logic            run_ok, acc0, acc1, take_redirect;
  logic            pop;
  entry_t          ent0, ent1;

  // Outcome evaluation per port: direction wrong, or taken to the wrong place.
  assign mis0 = (ex0_pred_taken != ex0_taken) ||
                (ex0_taken && (ex0_pred_target != ex0_target));
  assign mis1 = (ex1_pred_taken != ex1_taken) ||
                (ex1_taken && (ex1_pred_target != ex1_target));
  assign fix0 = ex0_taken ? ex0_target : (ex0_pc + 64'd4);
  assign fix1 = ex1_taken ? ex1_target : (ex1_pc + 64'd4);

  assign run_ok = ready_q && (state_q == ST_RUN);
  assign acc0   = ex0_valid && run_ok;
  // A mispredicting ex0 makes ex1 wrong-path.
  assign acc1   = ex1_valid && run_ok && !(acc0 && mis0);
  assign take_redirect = (acc0 && mis0) || (acc1 && mis1);

  assign ent0 = '{uncond: ex0_uncond, taken: ex0_taken, pc: ex0_pc, target: ex0_target};
  assign ent1 = '{uncond: ex1_uncond, taken: ex1_taken, pc: ex1_pc, target: ex1_target};

  // FIFO next state: pop the head whenever present, append accepted ports in order.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    pop      = (cnt_q != '0);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (acc0) begin
      mem_d[wr_ptr_q] = ent0;
    end
    if (acc1) begin
      mem_d[wr_ptr_q + PW'(acc0)] = ent1;
    end
    wr_ptr_d = wr_ptr_q + PW'(acc0) + PW'(acc1);
    cnt_d    = cnt_q - CW'(pop) + CW'(acc0) + CW'(acc1);
  end

  // FSM and redirect bookkeeping.
  always_comb begin
    state_d    = state_q;
    sq_cnt_d   = sq_cnt_q;
    redir_v_d  = 1'b0;
    redir_pc_d = redir_pc_q;
    mcnt_d     = mcnt_q;
    case (state_q)
      ST_RUN: begin
        if (take_redirect) begin
          state_d    = ST_SQUASH;
          sq_cnt_d   = SW'(SQUASH_CYCLES - 1);
          redir_v_d  = 1'b1;
          redir_pc_d = (acc0 && mis0) ? fix0 : fix1;
          if (mcnt_q != 32'hFFFF_FFFF) begin
            mcnt_d = mcnt_q + 32'd1;
          end
        end
      end
      ST_SQUASH: begin
        if (sq_cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          sq_cnt_d = sq_cnt_q - SW'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Registered outputs are computed from next state so they describe the
  // cycle in which they are visible.
  always_comb begin
    cnt_left  = cnt_d - CW'(cnt_d != '0);
    ready_d   = (state_d == ST_RUN) && (cnt_left <= CW'(DEPTH - 2));
    head_d    = mem_d[rd_ptr_d];
    upd_brv_d = 1'b0;
    upd_br_d  = 1'b0;
    upd_btb_d = 1'b0;
    upd_pc_d  = 64'd0;
    upd_tgt_d = 64'd0;
    if (cnt_d != '0) begin
      upd_brv_d = !head_d.uncond;
      upd_br_d  = head_d.taken;
      upd_btb_d = head_d.taken;
      upd_pc_d  = head_d.pc;
      upd_tgt_d = head_d.target;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      sq_cnt_q   <= '0;
      ready_q    <= 1'b1;
      redir_v_q  <= 1'b0;
      redir_pc_q <= 64'd0;
      mcnt_q     <= 32'd0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      upd_brv_q  <= 1'b0;
      upd_br_q   <= 1'b0;
      upd_btb_q  <= 1'b0;
      upd_pc_q   <= 64'd0;
      upd_tgt_q  <= 64'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      sq_cnt_q   <= sq_cnt_d;
      ready_q    <= ready_d;
      redir_v_q  <= redir_v_d;
      redir_pc_q <= redir_pc_d;
      mcnt_q     <= mcnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      upd_brv_q  <= upd_brv_d;
      upd_br_q   <= upd_br_d;
      upd_btb_q  <= upd_btb_d;
      upd_pc_q   <= upd_pc_d;
      upd_tgt_q  <= upd_tgt_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign ex_ready       = ready_q;
  assign redirect_valid = redir_v_q;
  assign redirect_pc    = redir_pc_q;
  assign ex_br_valid    = upd_brv_q;
  assign ex_br          = upd_br_q;
  assign wr_btb_en      = upd_btb_q;
  assign ex_pc_idx      = upd_pc_q;
  assign target_pc      = upd_tgt_q;
  assign mispred_cnt    = mcnt_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_br_resolve.sv
// tb_br_resolve: directed vector table, hand sequences for ordering and
// mid-squash reset, and randomized traffic against a queue-based model.
module tb_br_resolve;

  localparam int DEPTH = 4;
  localparam int SQ    = 3;
  localparam int W     = 130;

  logic        clock;
  logic        reset;
  logic        ex0_valid, ex0_uncond, ex0_pred_taken, ex0_taken;
  logic [63:0] ex0_pc, ex0_pred_target, ex0_target;
  logic        ex1_valid, ex1_uncond, ex1_pred_taken, ex1_taken;
  logic [63:0] ex1_pc, ex1_pred_target, ex1_target;
  logic        ex_ready, redirect_valid, ex_br_valid, ex_br, wr_btb_en, dbg_state;
  logic [63:0] redirect_pc, ex_pc_idx, target_pc;
  logic [31:0] mispred_cnt;

  br_resolve #(.DEPTH(DEPTH), .SQUASH_CYCLES(SQ)) dut (
    .clock(clock), .reset(reset),
    .ex0_valid(ex0_valid), .ex0_pc(ex0_pc), .ex0_uncond(ex0_uncond),
    .ex0_pred_taken(ex0_pred_taken), .ex0_pred_target(ex0_pred_target),
    .ex0_taken(ex0_taken), .ex0_target(ex0_target),
    .ex1_valid(ex1_valid), .ex1_pc(ex1_pc), .ex1_uncond(ex1_uncond),
    .ex1_pred_taken(ex1_pred_taken), .ex1_pred_target(ex1_pred_target),
    .ex1_taken(ex1_taken), .ex1_target(ex1_target),
    .ex_ready(ex_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ex_br_valid(ex_br_valid), .ex_br(ex_br), .wr_btb_en(wr_btb_en),
    .ex_pc_idx(ex_pc_idx), .target_pc(target_pc), .mispred_cnt(mispred_cnt),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;
  int strobe_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending updates in program order, remaining squash cycles.
  logic [W-1:0] exp_q[$];
  int           squash_left;
  logic         m_rv;
  logic [63:0]  m_rpc;
  logic [31:0]  m_mcnt;

  function automatic bit is_mis(bit pt, bit t, logic [63:0] ptg, logic [63:0] tg);
    return (pt != t) || (t && (ptg != tg));
  endfunction

  function automatic logic [63:0] correct_pc(bit t, logic [63:0] pc, logic [63:0] tg);
    return t ? tg : pc + 64'd4;
  endfunction

  function automatic bit model_ready();
    int sz;
    sz = exp_q.size();
    return (squash_left == 0) && ((sz > 0 ? sz - 1 : 0) <= DEPTH - 2);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    squash_left = 0;
    m_rv   = 1'b0;
    m_rpc  = 64'd0;
    m_mcnt = 32'd0;
  endtask

  task automatic take_mispredict(input logic [63:0] pc);
    m_rv = 1'b1;
    m_rpc = pc;
    squash_left = SQ;
    if (m_mcnt != 32'hFFFF_FFFF) m_mcnt = m_mcnt + 32'd1;
  endtask

  task automatic check_outputs();
    logic [W-1:0] e;
    if (ex_br_valid || wr_btb_en) strobe_seen++;
    chk("ex_ready", ex_ready, model_ready());
    chk("dbg_state", dbg_state, squash_left > 0);
    chk("redirect_valid", redirect_valid, m_rv);
    if (m_rv) chk("redirect_pc", redirect_pc, m_rpc);
    chk("mispred_cnt", mispred_cnt, m_mcnt);
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      chk("ex_br_valid", ex_br_valid, !e[129]);
      chk("ex_br", ex_br, e[128]);
      chk("wr_btb_en", wr_btb_en, e[128]);
      chk("ex_pc_idx", ex_pc_idx, e[127:64]);
      chk("target_pc", target_pc, e[63:0]);
    end else begin
      chk("idle_br_valid", ex_br_valid, 1'b0);
      chk("idle_btb_en", wr_btb_en, 1'b0);
    end
  endtask

  task automatic model_advance();
    bit rdy, mis0;
    rdy = model_ready();
    m_rv = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    if (squash_left > 0) squash_left--;
    if (rdy) begin
      mis0 = ex0_valid && is_mis(ex0_pred_taken, ex0_taken, ex0_pred_target, ex0_target);
      if (ex0_valid) begin
        exp_q.push_back({ex0_uncond, ex0_taken, ex0_pc, ex0_target});
        if (mis0) take_mispredict(correct_pc(ex0_taken, ex0_pc, ex0_target));
      end
      if (ex1_valid && !mis0) begin
        exp_q.push_back({ex1_uncond, ex1_taken, ex1_pc, ex1_target});
        if (is_mis(ex1_pred_taken, ex1_taken, ex1_pred_target, ex1_target))
          take_mispredict(correct_pc(ex1_taken, ex1_pc, ex1_target));
      end
    end
  endtask

  // Called at a negedge with inputs driven; returns at the next negedge.
  task automatic cycle();
    check_outputs();
    model_advance();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Driver tasks
  task automatic clear_inputs();
    ex0_valid = 0; ex0_uncond = 0; ex0_pred_taken = 0; ex0_taken = 0;
    ex0_pc = '0; ex0_pred_target = '0; ex0_target = '0;
    ex1_valid = 0; ex1_uncond = 0; ex1_pred_taken = 0; ex1_taken = 0;
    ex1_pc = '0; ex1_pred_target = '0; ex1_target = '0;
  endtask

  task automatic gen_br(output logic u, output logic pt, output logic t,
                        output logic [63:0] pc, output logic [63:0] ptg,
                        output logic [63:0] tg);
    u   = ($urandom_range(0, 4) == 0);
    pc  = {$urandom, $urandom} & ~64'h3;
    ptg = {32'h0, $urandom} & ~64'h3;
    tg  = ($urandom_range(0, 9) < 8) ? ptg : ptg + 64'h40;
    if (u) begin
      pt = ($urandom_range(0, 9) < 9);
      t  = 1'b1;
    end else begin
      pt = 1'($urandom_range(0, 1));
      t  = ($urandom_range(0, 9) < 8) ? pt : !pt;
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 20 && (exp_q.size() != 0 || !model_ready()); k++) cycle();
    chk("wait_idle_ready", ex_ready, 1'b1);
  endtask

  typedef struct {
    logic        uncond, pred_taken, taken;
    logic [63:0] pc, pred_target, target;
    logic        with_ex1;
    logic        exp_redir;
    logic [63:0] exp_rpc;
    logic        exp_brv, exp_br, exp_btb;
    logic [63:0] exp_tpc;
    logic [31:0] exp_mcnt;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lowcnt;
    bit saw_low;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 64'h1000, 64'h1100, 64'h1100, 1'b0, 1'b0, 64'h0,    1'b1, 1'b0, 1'b0, 64'h1100, 32'd0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 64'h2000, 64'h2100, 64'h3000, 1'b1, 1'b1, 64'h3000, 1'b1, 1'b1, 1'b1, 64'h3000, 32'd1};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 64'h4000, 64'h500,  64'h600,  1'b0, 1'b1, 64'h600,  1'b0, 1'b1, 1'b1, 64'h600,  32'd2};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h10, 64'h10, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0, 1'b0, 64'h10, 32'd3};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 64'h5000, 64'h5800, 64'h5800, 1'b0, 1'b0, 64'h0,    1'b1, 1'b1, 1'b1, 64'h5800, 32'd3};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 64'h6000, 64'h6100, 64'h6200, 1'b0, 1'b1, 64'h6200, 1'b1, 1'b1, 1'b1, 64'h6200, 32'd4};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 64'h7000, 64'h7100, 64'h7100, 1'b0, 1'b1, 64'h7004, 1'b1, 1'b0, 1'b0, 64'h7100, 32'd5};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 64'h8000, 64'h9000, 64'h9000, 1'b0, 1'b0, 64'h0,    1'b0, 1'b1, 1'b1, 64'h9000, 32'd5};

    clear_inputs();
    model_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_ex_ready", ex_ready, 1'b1);
    chk("rst_redirect_valid", redirect_valid, 1'b0);
    chk("rst_redirect_pc", redirect_pc, 64'h0);
    chk("rst_ex_br_valid", ex_br_valid, 1'b0);
    chk("rst_wr_btb_en", wr_btb_en, 1'b0);
    chk("rst_mispred_cnt", mispred_cnt, 32'h0);
    reset = 1'b1;

    // Directed vector table: one branch on ex0 from an idle pipe.
    for (int i = 0; i < 8; i++) begin
      wait_idle();
      ex0_valid = 1'b1; ex0_uncond = vecs[i].uncond; ex0_pc = vecs[i].pc;
      ex0_pred_taken = vecs[i].pred_taken; ex0_pred_target = vecs[i].pred_target;
      ex0_taken = vecs[i].taken; ex0_target = vecs[i].target;
      if (vecs[i].with_ex1) begin
        ex1_valid = 1'b1; ex1_pc = vecs[i].pc + 64'd4;
        ex1_pred_taken = 1'b0; ex1_taken = 1'b0; ex1_target = 64'h1234;
      end
      cycle();
      clear_inputs();
      chk("vec_redirect_valid", redirect_valid, vecs[i].exp_redir);
      if (vecs[i].exp_redir) chk("vec_redirect_pc", redirect_pc, vecs[i].exp_rpc);
      chk("vec_ex_br_valid", ex_br_valid, vecs[i].exp_brv);
      chk("vec_ex_br", ex_br, vecs[i].exp_br);
      chk("vec_wr_btb_en", wr_btb_en, vecs[i].exp_btb);
      chk("vec_ex_pc_idx", ex_pc_idx, vecs[i].pc);
      chk("vec_target_pc", target_pc, vecs[i].exp_tpc);
      chk("vec_mispred_cnt", mispred_cnt, vecs[i].exp_mcnt);
      lowcnt = (ex_ready == 1'b0) ? 1 : 0;
      cycle();
      chk("vec_drained_brv", ex_br_valid, 1'b0);
      chk("vec_drained_btb", wr_btb_en, 1'b0);
      for (int k = 0; k < 10 && ex_ready == 1'b0; k++) begin
        lowcnt++;
        cycle();
      end
      chk("vec_ready_low_cycles", lowcnt, vecs[i].exp_redir ? SQ : 0);
    end

    // Four correct pairs back to back: ready must dip, order must hold.
    wait_idle();
    strobe_seen = 0;
    saw_low = 0;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 10 && !model_ready(); k++) begin
        saw_low = 1;
        cycle();
      end
      ex0_valid = 1; ex0_pc = 64'hA000 + 64'(16 * i); ex0_pred_taken = 0; ex0_taken = 0;
      ex0_pred_target = 64'hA100; ex0_target = 64'hA100;
      ex1_valid = 1; ex1_pc = 64'hA004 + 64'(16 * i); ex1_pred_taken = 1; ex1_taken = 1;
      ex1_pred_target = 64'hB000 + 64'(16 * i); ex1_target = 64'hB000 + 64'(16 * i);
      cycle();
      clear_inputs();
    end
    for (int k = 0; k < 8; k++) cycle();
    chk("pairs_ready_dropped", saw_low, 1'b1);
    chk("pairs_update_count", strobe_seen, 8);

    // Reset in the middle of a squash with three entries queued.
    wait_idle();
    ex0_valid = 1; ex0_pc = 64'hC000; ex0_target = 64'hC100; ex0_pred_target = 64'hC100;
    ex1_valid = 1; ex1_pc = 64'hC004; ex1_target = 64'hC200; ex1_pred_target = 64'hC200;
    cycle();
    clear_inputs();
    ex0_valid = 1; ex0_pc = 64'hC010; ex0_target = 64'hC300; ex0_pred_target = 64'hC300;
    ex1_valid = 1; ex1_pc = 64'hC014; ex1_taken = 1; ex1_target = 64'hD000;
    ex1_pred_taken = 0; ex1_pred_target = 64'hD000;
    cycle();
    clear_inputs();
    chk("sq_queue_depth_model", exp_q.size(), 3);
    check_outputs();
    reset = 1'b0;
    #1;
    chk("midrst_ex_ready", ex_ready, 1'b1);
    chk("midrst_redirect_valid", redirect_valid, 1'b0);
    chk("midrst_redirect_pc", redirect_pc, 64'h0);
    chk("midrst_ex_br_valid", ex_br_valid, 1'b0);
    chk("midrst_wr_btb_en", wr_btb_en, 1'b0);
    chk("midrst_ex_pc_idx", ex_pc_idx, 64'h0);
    chk("midrst_mispred_cnt", mispred_cnt, 32'h0);
    chk("midrst_dbg_state", dbg_state, 1'b0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    strobe_seen = 0;
    for (int k = 0; k < 6; k++) cycle();
    chk("postrst_no_drain", strobe_seen, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      clear_inputs();
      if (model_ready()) begin
        if ($urandom_range(0, 99) < 70) begin
          ex0_valid = 1;
          gen_br(ex0_uncond, ex0_pred_taken, ex0_taken, ex0_pc, ex0_pred_target, ex0_target);
        end
        if ($urandom_range(0, 99) < 60) begin
          ex1_valid = 1;
          gen_br(ex1_uncond, ex1_pred_taken, ex1_taken, ex1_pc, ex1_pred_target, ex1_target);
        end
      end
      cycle();
    end
    clear_inputs();
    for (int k = 0; k < 10; k++) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/br_resolve.md
# br_resolve

Execute-side branch resolution and predictor-update block. It takes up to two resolved branches per cycle from the branch functional units and compares each actual outcome against the prediction carried down the pipe. It issues a fetch redirect on a mispredict and serializes training updates, one per cycle, onto the predictor's execute-update interface (ex_br_valid / ex_br / wr_btb_en / ex_pc_idx / target_pc). It sits between the branch FUs and the fetch-stage predictor.

## Interface
- DEPTH, 4: update FIFO entries (power of 2, ≥4)
- SQUASH_CYCLES, 3: cycles of wrong-path input suppression after a redirect (≥1)

Ports:
- clock  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- exN_valid  in  1  (N=0,1) resolved branch present; ex0 is older than ex1 in the same cycle
- exN_pc  in  64  branch PC
- exN_uncond  in  1  unconditional branch/jump
- exN_pred_taken  in  1  direction predicted at fetch
- exN_pred_target  in  64  target predicted at fetch
- exN_taken  in  1  actual direction (must be 1 when uncond)
- exN_target  in  64  actual taken target
- ex_ready  out  1  both ports may present a branch this cycle
- redirect_valid  out  1  one-cycle redirect pulse to fetch
- redirect_pc  out  64  correct fetch PC
- ex_br_valid  out  1  conditional-branch direction update
- ex_br  out  1  actual direction for the update
- wr_btb_en  out  1  BTB write
- ex_pc_idx  out  64  PC of the updating branch
- target_pc  out  64  actual target for the BTB write
- mispred_cnt  out  32  saturating mispredict count

## Operation
- Mispredict for a branch:
  - pred_taken ≠ taken, or
  - taken && pred_target ≠ target.
- Correct PC: taken ? target : pc + 4, computed with 64-bit wrap-around.
- Acceptance: a port is accepted when valid && ex_ready && state==RUN.
  - When ex0 is accepted and mispredicts, ex1 is squashed: not enqueued, not counted.
  - Inputs that arrive while ex_ready=0 are ignored. Upstream must not present them.
- Enqueue order: ex0 then ex1. The mispredicting branch itself is enqueued so that the predictor trains on it.
- Each FIFO entry holds {uncond, taken, pc, target}.
- Drain: the head is popped every cycle the FIFO is non-empty. The predictor never stalls.
- Update output mapping for the popped entry:
  - ex_br_valid = !uncond
  - ex_br = taken
  - wr_btb_en = taken
  - ex_pc_idx = pc
  - target_pc = target
- When the FIFO is empty, all update strobes are 0.
- ex_ready = (state==RUN) && (count ≤ DEPTH−2), where count is the value after this cycle's pop.
- FSM:
  - RUN: on an accepted mispredict, register the redirect and go to SQUASH with sq_cnt=SQUASH_CYCLES−1.
  - SQUASH: inputs are ignored and ex_ready=0. sq_cnt decrements each cycle; at 0, return to RUN.
  - The FIFO keeps draining in SQUASH; its entries are all older than the mispredict and remain valid.
- mispred_cnt increments by at most 1 per cycle and saturates at 0xFFFF_FFFF.
- Reset values: state=RUN, FIFO empty, ex_ready=1, redirect_valid=0, redirect_pc=0, every update output 0, mispred_cnt=0.
- Reset asserted mid-operation discards FIFO contents and any pending redirect or squash.

## Timing
- Branch accepted in cycle N:
  - enqueued at the edge ending N;
  - if the FIFO was empty, its update is driven in cycle N+1.
- Entries drain one per cycle in FIFO order. The k-th queued entry appears at head-of-queue + k.
- Mispredict accepted in cycle N:
  - redirect_valid=1 with redirect_pc in N+1 only;
  - mispred_cnt is updated in N+1;
  - ex_ready=0 for cycles N+1 … N+SQUASH_CYCLES;
  - acceptance resumes in N+SQUASH_CYCLES+1.
- Simultaneous enqueue and pop in one cycle is legal. Count changes by (enq − pop).
- Pointers wrap modulo DEPTH. Full and empty are distinguished by count.
- All outputs are registered; none combinationally depend on ex* inputs.

## Test plan
- Reset, then ex0 conditional at pc=0x1000, pred NT, actual NT:
  - cycle+1: ex_br_valid=1, ex_br=0, wr_btb_en=0, ex_pc_idx=0x1000;
  - no redirect.
- ex0 pc=0x2000 pred NT, actual T, target 0x3000, with ex1 valid:
  - redirect_valid pulse, redirect_pc=0x3000, mispred_cnt=1;
  - ex1 is dropped;
  - ex_ready=0 for exactly 3 cycles.
- ex0 unconditional, pred T, target 0x500 but actual target 0x600:
  - redirect to 0x600;
  - update has ex_br_valid=0, wr_btb_en=1, target_pc=0x600.
- Both ports valid and correct for 4 consecutive cycles:
  - ex_ready drops once count reaches 3;
  - updates emerge one per cycle in program order, none lost or duplicated.
- Assert reset low mid-squash with 3 queued entries:
  - outputs are immediately zero and ex_ready=1;
  - nothing drains after release.
- Taken branch at pc=0xFFFF_FFFF_FFFF_FFFC predicted T that resolves NT:
  - redirect_pc=0x0 (wrap-around).
